piso_tx_ctrl: RTL and testbench
===============================

# piso_tx_ctrl

Serial transmit controller that owns a parallel-in/serial-out shift register and sequences it. It accepts N-bit words over a valid/ready handshake, parallel-loads each word, shifts it out LSB-first, one bit per clock, and marks frame boundaries. An optional inter-frame gap can be inserted. It sits between a word-producing datapath and a single-wire serial link.

## Interface
- `N`, default 4: word width in bits; legal range N ≥ 2.
- `GAP`, default 0: idle cycles forced between frames; legal range 0 to 15.
- `FILL`, default 1'b0: serial-in bit shifted into the MSB on each shift.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset_n` input 1: reset is synchronous and active-low.
- `in_valid` input 1: producer has a word on `in_data`.
- `in_data` input N: word to transmit.
- `in_ready` output 1: controller accepts a word this cycle.
- `so` output 1: serial data, registered, equal to shift register bit 0.
- `so_valid` output 1: `so` carries a frame bit this cycle.
- `frame_start` output 1: `so` is bit 0 of a frame.
- `frame_last` output 1: `so` is bit N-1 of a frame.
- `busy` output 1: state is not IDLE.

## Operation
- States:
  - IDLE: no frame in progress.
  - SHIFT: frame bits are on `so`.
  - GAP: forced idle between frames.
- Bit counter `cnt` is $clog2(N) bits wide. Gap counter `gcnt` is 4 bits wide.
- A transfer occurs when `in_valid && in_ready` are both high at a rising edge.
- `in_ready` is combinational:
  - It is 1 in IDLE.
  - It is 1 in SHIFT when `cnt == N-1` and `GAP == 0`.
  - It is 0 in every other case, and it is forced to 0 while `reset_n` is low.
- On a transfer:
  - The shift register loads `in_data`, `cnt` becomes 0, and the state becomes SHIFT.
  - Load has priority over shift.
- SHIFT:
  - Each cycle, the register shifts right with FILL entering the MSB.
  - `cnt` increments by 1.
  - `so_valid` is 1.
  - `frame_start` is 1 when `cnt == 0`.
  - `frame_last` is 1 when `cnt == N-1`.
- Exit from SHIFT at `cnt == N-1`:
  - If a transfer occurs in that cycle, the next word is loaded and the state stays SHIFT with `cnt` = 0. There is no bubble.
  - Otherwise, if `GAP > 0`, the state becomes GAP with `gcnt` = GAP-1.
  - Otherwise the state becomes IDLE.
- GAP: `gcnt` decrements each cycle. When `gcnt == 0`, the state becomes IDLE.
- `in_data` is sampled only on a transfer edge. A producer holding `in_valid` while `in_ready` is 0 is stalled, and its word is not lost.
- Outputs when not in SHIFT:
  - `so_valid`, `frame_start` and `frame_last` are 0.
  - `so` holds whatever is in register bit 0; consumers qualify `so` with `so_valid`.

## Timing
- Reset: while `reset_n` is low at an edge, the following clear on that edge:
  - state becomes IDLE;
  - shift register, `cnt` and `gcnt` become 0;
  - `so`, `so_valid`, `frame_start`, `frame_last` and `busy` become 0.
- After `reset_n` goes high, `in_ready` is 1 in the same cycle.
- Reset mid-frame aborts the frame. No further bits are emitted, and the word is dropped.
- Latency: for a transfer at edge k, bit 0 is on `so` in cycle k+1 and bit N-1 in cycle k+N.
- Throughput:
  - With GAP = 0 and a continuous producer: one word per N cycles, with `so_valid` continuously high.
  - With GAP = G: one word per N+G+1 cycles, because the IDLE cycle is needed to accept the next word.
- `so` changes only on rising edges. It is glitch-free.

## Structure
- Shared package `piso_pkg` holds:
  - the state typedef, `IDLE`, `SHIFT`, `GAP`, 2-bit encoded;
  - the constant for the gap counter width, 4.
- Sub-module `piso_shift_reg`: N-bit register with these ports:
  - `clk`, `reset_n` (synchronous, active-low);
  - `load`, `shift_en`, `SI`, `I[N-1:0]`;
  - outputs `Q` and `SO`.
  - `load` has priority over `shift_en`.
- The controller contains the FSM, the counters and the output decode only.

## Test plan
- **Single word:** N = 4, GAP = 0; transfer `in_data` = 4'b1011 at edge k.
  - `so` is 1,1,0,1 on cycles k+1 through k+4.
  - `frame_start` is high at k+1 only and `frame_last` at k+4 only.
  - The state is IDLE at k+5.
- **Back-to-back:** N = 4, GAP = 0; `in_valid` held high with 4'hA then 4'h5.
  - `so` is 0,1,0,1,1,0,1,0.
  - `so_valid` stays high for 8 cycles.
  - `in_ready` is high only on `frame_last` cycles after the first transfer.
- **Gap:** N = 4, GAP = 2; two queued words.
  - After the first `frame_last`, `so_valid` is 0 for 3 cycles: 2 GAP cycles plus 1 IDLE accept cycle.
  - The second frame then starts and is correct.
- **Stall:** `in_valid` is raised with 4'h3 during SHIFT of 4'hC at `cnt` = 1, with GAP = 1.
  - 4'h3 is not consumed until IDLE.
  - It is then transmitted as 1,1,0,0.
- **Mid-frame reset:** `reset_n` is driven low for 1 cycle at `cnt` = 2.
  - At the next edge all outputs are 0 and the state is IDLE.
  - `in_ready` is 1 once `reset_n` is high.
  - A new word then transmits correctly.
- **Width:** N = 8, FILL = 1; word 8'h81.
  - `so` is 1,0,0,0,0,0,0,1.
  - The register reads 8'hFF after the frame.

Source files
------------

// File: rtl/piso_pkg.sv
// Shared types and constants for the PISO transmit controller.
package piso_pkg;

  localparam int GCNT_W = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/piso_shift_reg.sv
// N-bit parallel-in/serial-out register, shifting right; load beats shift.
module piso_shift_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift_en,
  input  logic         SI,
  input  logic [N-1:0] I,
  output logic [N-1:0] Q,
  output logic         SO
);

  logic [N-1:0] q_reg;
  logic [N-1:0] q_next;

  // Each bit picks its parallel input, its left neighbour (SI for the MSB) or itself.
  for (genvar gi = 0; gi < N; gi++) begin : g_bit
    if (gi == N - 1) begin : g_msb
      assign q_next[gi] = load ? I[gi] : (shift_en ? SI : q_reg[gi]);
    end else begin : g_lower
      assign q_next[gi] = load ? I[gi] : (shift_en ? q_reg[gi+1] : q_reg[gi]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      q_reg <= '0;
    end else begin
      q_reg <= q_next;
    end
  end

  assign Q  = q_reg;
  assign SO = q_reg[0];

endmodule

// File: rtl/piso_tx_ctrl.sv
// Serial transmit controller: accepts words on valid/ready, sends them LSB-first
// with frame markers and an optional forced gap between frames.
module piso_tx_ctrl #(
  parameter int   N    = 4,
  parameter int   GAP  = 0,
  parameter logic FILL = 1'b0
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  input  logic [N-1:0] in_data,
  output logic         in_ready,
  output logic         so,
  output logic         so_valid,
  output logic         frame_start,
  output logic         frame_last,
  output logic         busy
);
  import piso_pkg::*;

  localparam int                CW       = $clog2(N);
  localparam logic [CW-1:0]     LAST     = CW'(N - 1);
  localparam logic [GCNT_W-1:0] GAP_INIT = GCNT_W'(GAP > 0 ? GAP - 1 : 0);
  localparam logic              NO_GAP   = (GAP == 0);

  state_t              state_reg, state_next;
  logic [CW-1:0]       cnt_reg, cnt_next;
  logic [GCNT_W-1:0]   gcnt_reg, gcnt_next;
  logic                xfer;
  logic [N-1:0]        sr_q_unused;

  // The parameter GAP shadows the state label, so the state is named through the package.
  assign in_ready = reset_n &&
                    ((state_reg == IDLE) ||
                     (state_reg == SHIFT && cnt_reg == LAST && NO_GAP));
  assign xfer     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      gcnt_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      gcnt_reg  <= gcnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    gcnt_next  = gcnt_reg;
    case (state_reg)
      IDLE: begin
        if (xfer) begin
          state_next = SHIFT;
          cnt_next   = '0;
        end
      end
      SHIFT: begin
        if (xfer) begin
          cnt_next = '0;
        end else if (cnt_reg == LAST) begin
          cnt_next = '0;
          if (NO_GAP) begin
            state_next = IDLE;
          end else begin
            state_next = piso_pkg::GAP;
            gcnt_next  = GAP_INIT;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      piso_pkg::GAP: begin
        if (gcnt_reg == '0) begin
          state_next = IDLE;
        end else begin
          gcnt_next = gcnt_reg - 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    so_valid    = 1'b0;
    frame_start = 1'b0;
    frame_last  = 1'b0;
    busy        = (state_reg != IDLE);
    if (state_reg == SHIFT) begin
      so_valid    = 1'b1;
      frame_start = (cnt_reg == '0);
      frame_last  = (cnt_reg == LAST);
    end
  end

  piso_shift_reg #(.N(N)) u_sr (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (xfer),
    .shift_en (state_reg == SHIFT),
    .SI       (FILL),
    .I        (in_data),
    .Q        (sr_q_unused),
    .SO       (so)
  );

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Scoreboard bench for piso_tx_ctrl: four instances cover GAP=0, GAP=2, GAP=1 and N=8/FILL=1.
module tb_piso_tx_ctrl;

  typedef struct {
    logic so;
    logic fs;
    logic fl;
    int   k;
    int   gap;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int cmp_cnt = 0;
  int err_cnt = 0;

  logic       rst_n, rst0_n;
  logic       v_w   [4];
  logic [7:0] d_w   [4];
  logic       rdy_w [4];
  logic       so_w  [4];
  logic       sv_w  [4];
  logic       fs_w  [4];
  logic       fl_w  [4];
  logic       bz_w  [4];

  exp_t exp_q [4][$];
  int   last_fl [4];

  piso_tx_ctrl #(.N(4), .GAP(0)) u0 (
    .clk(clk), .reset_n(rst0_n), .in_valid(v_w[0]), .in_data(d_w[0][3:0]),
    .in_ready(rdy_w[0]), .so(so_w[0]), .so_valid(sv_w[0]),
    .frame_start(fs_w[0]), .frame_last(fl_w[0]), .busy(bz_w[0]));

  piso_tx_ctrl #(.N(4), .GAP(2)) u1 (
    .clk(clk), .reset_n(rst_n), .in_valid(v_w[1]), .in_data(d_w[1][3:0]),
    .in_ready(rdy_w[1]), .so(so_w[1]), .so_valid(sv_w[1]),
    .frame_start(fs_w[1]), .frame_last(fl_w[1]), .busy(bz_w[1]));

  piso_tx_ctrl #(.N(4), .GAP(1)) u2 (
    .clk(clk), .reset_n(rst_n), .in_valid(v_w[2]), .in_data(d_w[2][3:0]),
    .in_ready(rdy_w[2]), .so(so_w[2]), .so_valid(sv_w[2]),
    .frame_start(fs_w[2]), .frame_last(fl_w[2]), .busy(bz_w[2]));

  piso_tx_ctrl #(.N(8), .GAP(0), .FILL(1'b1)) u3 (
    .clk(clk), .reset_n(rst_n), .in_valid(v_w[3]), .in_data(d_w[3]),
    .in_ready(rdy_w[3]), .so(so_w[3]), .so_valid(sv_w[3]),
    .frame_start(fs_w[3]), .frame_last(fl_w[3]), .busy(bz_w[3]));

  task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
    cmp_cnt++;
    if (act !== expv) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  task automatic mon(int i);
    exp_t e;
    if (sv_w[i] === 1'b1) begin
      if (exp_q[i].size() == 0) begin
        cmp_cnt++;
        err_cnt++;
        $display("FAIL u%0d unexpected bit: got so=%0b at cycle %0d expected no frame bit",
                 i, so_w[i], cyc);
      end else begin
        e = exp_q[i].pop_front();
        chk($sformatf("u%0d so/fs/fl", i), {29'd0, so_w[i], fs_w[i], fl_w[i]},
            {29'd0, e.so, e.fs, e.fl});
        if (e.fs && e.k >= 0)
          chk($sformatf("u%0d latency", i), cyc, e.k);
        if (e.fs && e.gap >= 0)
          chk($sformatf("u%0d idle gap", i), cyc - last_fl[i] - 1, e.gap);
        if (i == 0)
          chk("u0 in_ready", {31'd0, rdy_w[0]}, {31'd0, e.fl});
        if (fl_w[i] === 1'b1) last_fl[i] = cyc;
      end
    end
  endtask

  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) mon(i);
  end

  // Raises valid with word, waits for ready, queues the expected frame, returns after the transfer edge.
  task automatic send(int i, logic [7:0] word, int n, int gap);
    exp_t e;
    int   t;
    int   k;
    d_w[i] = word;
    v_w[i] = 1'b1;
    t = 0;
    while (rdy_w[i] !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (rdy_w[i] !== 1'b1) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL u%0d accept timeout: got in_ready=%0b expected 1", i, rdy_w[i]);
      v_w[i] = 1'b0;
      return;
    end
    k = cyc + 1;
    for (int b = 0; b < n; b++) begin
      e.so  = word[b];
      e.fs  = (b == 0);
      e.fl  = (b == n - 1);
      e.k   = (b == 0) ? k : -1;
      e.gap = (b == 0) ? gap : -1;
      exp_q[i].push_back(e);
    end
    $display("u%0d word 0x%0h accepted at edge %0d", i, word, k);
    @(negedge clk);
  endtask

  task automatic drain(int i);
    int t = 0;
    while (exp_q[i].size() > 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (exp_q[i].size() > 0) begin
      cmp_cnt++;
      err_cnt++;
      $display("FAIL u%0d drain timeout: got %0d bits pending expected 0", i, exp_q[i].size());
      exp_q[i].delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    rst0_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      v_w[i]     = 1'b0;
      d_w[i]     = 8'h00;
      last_fl[i] = 0;
    end
    repeat (3) @(negedge clk);

    // Reset state
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("u%0d reset outputs", i),
          {27'd0, so_w[i], sv_w[i], fs_w[i], fl_w[i], bz_w[i]}, 32'd0);
      chk($sformatf("u%0d reset in_ready", i), {31'd0, rdy_w[i]}, 32'd0);
    end
    rst_n  = 1'b1;
    rst0_n = 1'b1;
    #1;
    for (int i = 0; i < 4; i++)
      chk($sformatf("u%0d in_ready after reset", i), {31'd0, rdy_w[i]}, 32'd1);
    @(negedge clk);

    // Single word 1011 -> 1,1,0,1 then IDLE
    send(0, 8'h0B, 4, -1);
    v_w[0] = 1'b0;
    drain(0);
    @(negedge clk);
    chk("u0 idle after single", {31'd0, bz_w[0]}, 32'd0);

    // Back-to-back A then 5 with no bubble
    send(0, 8'h0A, 4, -1);
    send(0, 8'h05, 4, 0);
    v_w[0] = 1'b0;
    drain(0);

    // GAP=2: 2 gap cycles plus one accept cycle between frames
    send(1, 8'h06, 4, -1);
    send(1, 8'h09, 4, 3);
    v_w[1] = 1'b0;
    drain(1);

    // Stall: 3 offered at cnt=1 of C with GAP=1, consumed only in IDLE
    send(2, 8'h0C, 4, -1);
    v_w[2] = 1'b0;
    @(negedge clk);
    send(2, 8'h03, 4, 2);
    v_w[2] = 1'b0;
    drain(2);

    // N=8, FILL=1: 81 goes out as 1,0,0,0,0,0,0,1 and the register fills with ones
    send(3, 8'h81, 8, -1);
    v_w[3] = 1'b0;
    drain(3);
    @(negedge clk);
    chk("u3 register after frame", {24'd0, u3.u_sr.Q}, 32'h0000_00FF);
    chk("u3 so after frame", {31'd0, so_w[3]}, 32'd1);

    // Mid-frame reset at cnt=2 drops the frame
    send(0, 8'h06, 4, -1);
    v_w[0] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst0_n = 1'b0;
    exp_q[0].delete();
    @(negedge clk);
    chk("u0 outputs after mid reset",
        {27'd0, so_w[0], sv_w[0], fs_w[0], fl_w[0], bz_w[0]}, 32'd0);
    chk("u0 in_ready in reset", {31'd0, rdy_w[0]}, 32'd0);
    rst0_n = 1'b1;
    #1;
    chk("u0 in_ready after mid reset", {31'd0, rdy_w[0]}, 32'd1);
    @(negedge clk);
    send(0, 8'h0D, 4, -1);
    v_w[0] = 1'b0;
    drain(0);

    repeat (4) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
